sat_value_uart_tx: RTL and testbench

- Reader/reporting end of the saturation path. It watches the (WIDTH+1)-bit saturating register value that the up/down button logic drives.
- Whenever the value changes, or a resend is requested, it serialises the value as one 8N1 UART frame on a single TX line.
- Sits between the saturation counter output and the board UART pin, in parallel with the LED indicator logic.

---
 rtl/sat_value_uart_tx.sv | 111 +++++++++++
 tb/tb_sat_value_uart_tx.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sat_value_uart_tx.sv
// sat_value_uart_tx: reports the saturating register value as one
// 8N1 UART frame whenever it changes or a resend is requested.
module sat_value_uart_tx #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [WIDTH:0] value,
  input  logic           send_req,
  output logic           tx,
  output logic           busy,
  output logic           frame_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [CW-1:0]  baud_cnt;
  logic [2:0]     bit_idx;
  logic           pending;
  logic [WIDTH:0] prev_value;
  logic [7:0]     data_reg;

  logic change;
  logic trigger;
  logic bit_end;

  assign change  = (value != prev_value);
  assign trigger = change | send_req | pending;
  assign bit_end = (baud_cnt == CNT_MAX);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode: every bit lasts one full baud period
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (trigger) state_nxt = START;
      START: if (bit_end) state_nxt = DATA;
      DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
      STOP:  if (bit_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Baud counter and bit index; counter reloads on every bit boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      if (state == IDLE || bit_end) baud_cnt <= '0;
      else                          baud_cnt <= baud_cnt + 1'b1;
      if (state != DATA)  bit_idx <= '0;
      else if (bit_end)   bit_idx <= bit_idx + 1'b1;
    end
  end

  // Change detect, frame latch and single-deep pending flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_value <= '0;
      data_reg   <= '0;
      pending    <= 1'b0;
    end else begin
      prev_value <= value;
      if (state == IDLE) begin
        if (trigger) begin
          data_reg <= 8'(value);
          pending  <= 1'b0;
        end
      end else if (change | send_req) begin
        pending <= 1'b1;
      end
    end
  end

  // Busy flag registered from the upcoming state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= 1'b0;
    else     busy <= (state_nxt != IDLE);
  end

  // Line driver and end-of-frame strobe
  always_comb begin
    tx         = 1'b1;
    frame_done = 1'b0;
    unique case (state)
      IDLE:  tx = 1'b1;
      START: tx = 1'b0;
      DATA:  tx = data_reg[bit_idx];
      STOP:  frame_done = bit_end;
      default: tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_sat_value_uart_tx.sv
// tb_sat_value_uart_tx: frame-level reference model plus line decoder
// checking sat_value_uart_tx cycle by cycle and byte by byte.
module tb_sat_value_uart_tx;

  localparam int W   = 4;
  localparam int CPB = 4;
  localparam int FL  = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [W:0] value = '0;
  logic       send_req = 1'b0;
  logic       tx;
  logic       busy;
  logic       frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sat_value_uart_tx #(
    .WIDTH(W),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .value(value),
    .send_req(send_req),
    .tx(tx),
    .busy(busy),
    .frame_done(frame_done)
  );

  // Reference model: a frame is a position 0..FL-1 within a 10-bit window
  logic       m_act;
  int         m_k;
  logic [7:0] m_byte;
  logic       m_pend;
  logic [W:0] m_prev;
  logic [7:0] exp_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act  <= 1'b0;
      m_k    <= 0;
      m_byte <= '0;
      m_pend <= 1'b0;
      m_prev <= '0;
    end else begin
      m_prev <= value;
      if (!m_act) begin
        if (value != m_prev || send_req || m_pend) begin
          m_act  <= 1'b1;
          m_k    <= 0;
          m_byte <= 8'(value);
          m_pend <= 1'b0;
          exp_q.push_back(8'(value));
        end
      end else begin
        if (value != m_prev || send_req) m_pend <= 1'b1;
        if (m_k == FL - 1) m_act <= 1'b0;
        else               m_k <= m_k + 1;
      end
    end
  end

  logic e_tx;
  logic e_busy;
  logic e_fd;

  always_comb begin
    e_tx = 1'b1;
    if (m_act) begin
      if (m_k < CPB)          e_tx = 1'b0;
      else if (m_k < 9 * CPB) e_tx = m_byte[3'(m_k / CPB - 1)];
    end
    e_busy = m_act;
    e_fd   = m_act && (m_k == FL - 1);
  end

  // Line decoder: samples mid-bit, collects bytes, counts bad stop bits
  logic       rx_act = 1'b0;
  int         rx_k = 0;
  logic [7:0] rx_sh = '0;
  logic [7:0] rx_q[$];
  int         stop_bad = 0;

  always @(negedge clk) begin
    if (rst) begin
      rx_act <= 1'b0;
      rx_k   <= 0;
    end else if (!rx_act) begin
      if (tx === 1'b0) begin
        rx_act <= 1'b1;
        rx_k   <= 1;
      end
    end else begin
      rx_k <= rx_k + 1;
      if (rx_k % CPB == CPB / 2) begin
        if (rx_k / CPB >= 1 && rx_k / CPB <= 8) begin
          rx_sh[3'(rx_k / CPB - 1)] <= tx;
        end else if (rx_k / CPB == 9) begin
          rx_q.push_back(rx_sh);
          if (tx !== 1'b1) stop_bad <= stop_bad + 1;
          rx_act <= 1'b0;
        end
      end
    end
  end

  task automatic test_reset();
    int bc;
    bc = 0;
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({tx, busy, frame_done} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_out tx/busy/fd got %b%b%b want 100",
               tx, busy, frame_done);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rx_q.delete();
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      n_tests++;
      if ({tx, busy, frame_done} !== {e_tx, e_busy, e_fd}) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL reset_cyc c=%0d got %b%b%b want %b%b%b", c,
                   tx, busy, frame_done, e_tx, e_busy, e_fd);
      end
      if (busy !== 1'b0) bc++;
    end
    n_tests++;
    if (rx_q.size() != 0 || bc != 0) begin
      n_fail++;
      $display("FAIL reset_idle frames %0d busy_cycles %0d want 0 0",
               rx_q.size(), bc);
    end
  endtask

  task automatic test_single();
    int bc, first_b, fd_c, lo;
    bc = 0; first_b = -1; fd_c = -1; lo = 0;
    rx_q.delete();
    for (int c = 0; c < 60; c++) begin
      if (c > 0) @(negedge clk);
      if (c > 0) begin
        n_tests++;
        if ({tx, busy, frame_done} !== {e_tx, e_busy, e_fd}) begin
          n_fail++;
          if (n_fail <= 20)
            $display("FAIL single_cyc c=%0d got %b%b%b want %b%b%b", c,
                     tx, busy, frame_done, e_tx, e_busy, e_fd);
        end
        if (busy === 1'b1) begin
          bc++;
          if (first_b < 0) first_b = c;
        end
        if (frame_done === 1'b1 && fd_c < 0) fd_c = c;
        if (c >= 1 && c <= 4 && tx === 1'b0) lo++;
      end
      if (c == 0) value = 5'd5;
    end
    n_tests++;
    if (first_b != 1 || bc != 40 || lo != 4) begin
      n_fail++;
      $display("FAIL single_timing first %0d busy %0d startlow %0d want 1 40 4",
               first_b, bc, lo);
    end
    n_tests++;
    if (fd_c != 40) begin
      n_fail++;
      $display("FAIL single_done at %0d want 40", fd_c);
    end
    n_tests++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h05) begin
      n_fail++;
      $display("FAIL single_byte n=%0d got %h want 1 05", rx_q.size(),
               (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_coalesce();
    logic [31:0] got;
    int fd_c, st_c;
    got = '0; fd_c = -1; st_c = -1;
    rx_q.delete();
    for (int c = 0; c < 140; c++) begin
      @(negedge clk);
      n_tests++;
      if ({tx, busy, frame_done} !== {e_tx, e_busy, e_fd}) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL coal_cyc c=%0d got %b%b%b want %b%b%b", c,
                   tx, busy, frame_done, e_tx, e_busy, e_fd);
      end
      if (c > 45 && frame_done === 1'b1 && fd_c < 0) fd_c = c;
      if (fd_c >= 0 && st_c < 0 && c > fd_c && tx === 1'b0) st_c = c;
      if (c == 0)  value = 5'd0;
      if (c == 45) value = 5'd5;
      if (c == 55) value = 5'd6;
      if (c == 65) value = 5'd7;
    end
    foreach (rx_q[i]) got = {got[23:0], rx_q[i]};
    n_tests++;
    if (rx_q.size() != 3 || got !== 32'h0000_0507) begin
      n_fail++;
      $display("FAIL coal_bytes n=%0d got %h want 3 00000507",
               rx_q.size(), got);
    end
    n_tests++;
    if (st_c - fd_c != 2) begin
      n_fail++;
      $display("FAIL coal_gap got %0d want 2", st_c - fd_c);
    end
  endtask

  task automatic test_send_req();
    logic [31:0] got;
    int fdn, fd_c, st_c;
    got = '0; fdn = 0; fd_c = -1; st_c = -1;
    rx_q.delete();
    for (int c = 0; c < 140; c++) begin
      @(negedge clk);
      n_tests++;
      if ({tx, busy, frame_done} !== {e_tx, e_busy, e_fd}) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL sreq_cyc c=%0d got %b%b%b want %b%b%b", c,
                   tx, busy, frame_done, e_tx, e_busy, e_fd);
      end
      if (fd_c >= 0 && st_c < 0 && c > fd_c && tx === 1'b0) st_c = c;
      send_req = 1'b0;
      if (c == 0)  value = 5'd31;
      if (c == 45) send_req = 1'b1;
      if (frame_done === 1'b1) begin
        fdn++;
        if (fdn == 2) begin
          send_req = 1'b1;
          fd_c = c;
        end
      end
    end
    send_req = 1'b0;
    foreach (rx_q[i]) got = {got[23:0], rx_q[i]};
    n_tests++;
    if (rx_q.size() != 3 || got !== 32'h001F_1F1F) begin
      n_fail++;
      $display("FAIL sreq_bytes n=%0d got %h want 3 001f1f1f",
               rx_q.size(), got);
    end
    n_tests++;
    if (st_c - fd_c != 2) begin
      n_fail++;
      $display("FAIL sreq_edge gap got %0d want 2", st_c - fd_c);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    rx_q.delete();
    exp_q.delete();
    for (int c = 0; c < 3100; c++) begin
      @(negedge clk);
      n_tests++;
      if ({tx, busy, frame_done} !== {e_tx, e_busy, e_fd}) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL rand_cyc c=%0d got %b%b%b want %b%b%b", c,
                   tx, busy, frame_done, e_tx, e_busy, e_fd);
      end
      send_req = 1'b0;
      if (c < 3000) begin
        if ($urandom_range(0, 39) == 0) value = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 29) == 0) send_req = 1'b1;
      end
    end
    n_tests++;
    if (rx_q.size() != exp_q.size() || exp_q.size() < 10) begin
      n_fail++;
      $display("FAIL rand_count got %0d want %0d", rx_q.size(), exp_q.size());
    end else begin
      foreach (rx_q[i]) if (rx_q[i] !== exp_q[i]) errs++;
      n_tests++;
      if (errs != 0) begin
        n_fail++;
        $display("FAIL rand_bytes %0d bytes differ want 0", errs);
      end
    end
  endtask

  task automatic test_reset_mid();
    int hit;
    hit = 0;
    rx_q.delete();
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      n_tests++;
      if ({tx, busy, frame_done} !== {e_tx, e_busy, e_fd}) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL rmid_cyc c=%0d got %b%b%b want %b%b%b", c,
                   tx, busy, frame_done, e_tx, e_busy, e_fd);
      end
      if (c == 0) value = 5'd12;
      if (hit == 0 && m_act && m_k == 4 * CPB + 1) begin
        hit = c;
        value = 5'd9;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({tx, busy, frame_done} !== 3'b100) begin
          n_fail++;
          $display("FAIL rmid_async tx/busy/fd got %b%b%b want 100",
                   tx, busy, frame_done);
        end
      end
      if (hit > 0 && c == hit + 3) rst = 1'b0;
    end
    n_tests++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h09) begin
      n_fail++;
      $display("FAIL rmid_byte n=%0d got %h want 1 09", rx_q.size(),
               (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] want[$];
    int sb0, errs;
    errs = 0;
    sb0 = stop_bad;
    rx_q.delete();
    for (int v = 0; v <= 31; v++) want.push_back(8'(v));
    for (int v = 30; v >= 0; v--) want.push_back(8'(v));
    foreach (want[s]) begin
      value = 5'(want[s]);
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        n_tests++;
        if ({tx, busy, frame_done} !== {e_tx, e_busy, e_fd}) begin
          n_fail++;
          if (n_fail <= 20)
            $display("FAIL sweep_cyc s=%0d c=%0d got %b%b%b want %b%b%b",
                     s, c, tx, busy, frame_done, e_tx, e_busy, e_fd);
        end
      end
    end
    n_tests++;
    if (rx_q.size() != want.size()) begin
      n_fail++;
      $display("FAIL sweep_count got %0d want %0d", rx_q.size(), want.size());
    end else begin
      foreach (rx_q[i]) if (rx_q[i] !== want[i]) errs++;
      n_tests++;
      if (errs != 0) begin
        n_fail++;
        $display("FAIL sweep_bytes %0d differ want 0", errs);
      end
    end
    n_tests++;
    if (stop_bad != sb0) begin
      n_fail++;
      $display("FAIL sweep_stop bad stop bits %0d want 0", stop_bad - sb0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_coalesce();
    test_send_req();
    test_random();
    test_reset_mid();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
